uart2ahb_master: RTL and testbench
==================================

Name: uart2ahb_master

Overview:
Byte-stream command engine that turns the receive/transmit byte handshake of the UART core into single AHB master transfers. It gives a host PC debug and boot-load access to the system bus without the CPU. It sits between the uart core's rx/tx byte interface and a master port on the AHB interconnect, so it is the initiator counterpart of the memory-mapped UART slave. All AHB widths come from `AHB_ADDR_WIDTH and `AHB_DATA_WIDTH in const_defines.svh, both 32.

Parameters:
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles while a command is partially received; 0 disables the timeout.
ERR_BYTE, 8'hEE, response byte for a bus error or an unknown command.
ACK_BYTE, 8'h4B, response byte for a successful write.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous reset, active-high.
rx_valid  input  1  received byte available.
rx_data  input  8  received byte.
rx_ready  output  1  engine accepts a byte; transfer occurs when rx_valid & rx_ready.
tx_valid  output  1  response byte valid.
tx_data  output  8  response byte.
tx_ready  input  1  uart transmitter accepts the byte.
haddr  output  `AHB_ADDR_WIDTH  transfer address.
hwdata  output  `AHB_DATA_WIDTH  write data.
hwrite  output  1  1 = write, 0 = read.
hsel  output  1  transfer request.
hready  input  1  slave completes the transfer this cycle.
hresp  input  1  1 = error, sampled with hready.
hrdata  input  `AHB_DATA_WIDTH  read data, sampled with hready.
busy  output  1  high in any state other than CMD.

Behaviour:
- Reset (async, rst=1): state CMD. rx_ready, tx_valid, hsel, hwrite and busy are 0. haddr, hwdata and tx_data are 0.
- rx_ready is registered. It is 1 in CMD/ADDR/WDATA/CKSUM from the first cycle after reset is released, and 0 in BUS/RESP.
- Command format, little-endian:
  - Write: 'W' (8'h57), A0..A3, D0..D3.
  - Read: 'R' (8'h52), A0..A3.
- CMD: accept a byte.
  - 'W' or 'R': latch the direction and go to ADDR.
  - Any other byte: load ERR_BYTE into the response and go to RESP. No bus access.
- ADDR: shift in 4 bytes, A0 into haddr[7:0]. After the 4th byte, a write goes to WDATA and a read goes to BUS.
- WDATA: shift in 4 bytes into hwdata, D0 into [7:0], then go to BUS.
- BUS:
  - hsel=1 and hwrite=direction, starting the cycle after the last command byte is accepted.
  - haddr, hwdata and hwrite are held stable while hsel=1.
  - On the first clk edge with hready=1, capture hresp and hrdata, drop hsel on the next cycle, and go to RESP.
  - There is no bus timeout; the engine waits indefinitely for hready.
- RESP response queue:
  - hresp=1: 1 byte, ERR_BYTE.
  - Write OK: 1 byte, ACK_BYTE.
  - Read OK: 4 bytes, hrdata[7:0] first.
- RESP handshake:
  - tx_valid=1 with tx_data stable until tx_ready=1.
  - The next byte is presented the following cycle, so back-to-back bytes are possible.
  - After the last byte is accepted, tx_valid drops and the state returns to CMD.
- Inter-byte timeout (TIMEOUT_CYCLES>0):
  - The counter clears on each accepted byte and counts in ADDR/WDATA/CKSUM.
  - When it reaches TIMEOUT_CYCLES, the partial command is discarded, the state returns to CMD, and no response is sent.
  - A byte accepted in the same cycle the count reaches the limit wins: the byte is taken and the counter clears.
- Bytes arriving during BUS/RESP are back-pressured (rx_ready=0) and never dropped.
- rst asserted mid-transaction: hsel and tx_valid drop immediately, and all partial state is lost.
- An address is accepted as-is; alignment is not checked.

Optional Feature:
UART2AHB_CKSUM_EN:
- Defined: every command is followed by a checksum byte in state CKSUM, entered after the final address or data byte. The checksum is the XOR of all preceding command bytes, including the command byte.
- Checksum match: proceed to BUS.
- Checksum mismatch: respond with the single byte 8'hCE, do not touch the bus, and return to CMD.
- The timeout also applies in CKSUM.
- Not defined: the CKSUM state and its logic are absent, and commands are exactly as above.

Test Plan:
- Write: send 57 10 00 00 80 EF BE AD DE; slave hready=1 after 2 wait cycles -> one hsel pulse, 3 cycles long, with haddr=32'h80000010, hwdata=32'hDEADBEEF, hwrite=1; then tx byte 4B.
- Read: send 52 04 00 00 80; slave returns hrdata=32'h12345678 with zero wait -> hsel for exactly 1 cycle with hwrite=0; tx bytes 78 56 34 12 in order; tx_ready held low for 5 cycles before the 2nd byte -> tx_data holds 56.
- Bus error: a read with hready=1 and hresp=1 -> exactly one tx byte EE; state returns to CMD (busy=0).
- Unknown command: byte 41 -> tx EE, no hsel; a following valid read completes normally.
- Timeout: with TIMEOUT_CYCLES=50, send 57 10 then stall 50 cycles -> no response, busy=0; a fresh read then succeeds. A stall of 49 cycles followed by the next byte continues the command.
- Checksum (macro defined) and reset: read with a correct checksum byte (52^04^00^00^80 = D6) -> data returned; a wrong checksum -> tx CE, no hsel. Asserting rst while hsel=1 -> hsel=0 asynchronously, and rx_ready=1 one cycle after release.

Source files
------------

// File: rtl/uart2ahb_master.sv
// UART byte-stream to single-transfer AHB master bridge (W/R commands, little-endian).
// Optional checksum byte after each command: define UART2AHB_CKSUM_EN.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module uart2ahb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [`AHB_ADDR_WIDTH-1:0] haddr,
    output logic [`AHB_DATA_WIDTH-1:0] hwdata,
    output logic                       hwrite,
    output logic                       hsel,
    input  logic                       hready,
    input  logic                       hresp,
    input  logic [`AHB_DATA_WIDTH-1:0] hrdata,
    output logic                       busy
);

    localparam int unsigned AW = `AHB_ADDR_WIDTH;
    localparam int unsigned DW = `AHB_DATA_WIDTH;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

`ifdef UART2AHB_CKSUM_EN
    localparam logic [7:0] CKSUM_ERR = 8'hCE;
    typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_WDATA, ST_CKSUM, ST_BUS, ST_RESP} state_t;
`else
    typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_WDATA, ST_BUS, ST_RESP} state_t;
`endif

    state_t        state, nxt;
    logic          dir;
    logic [1:0]    byte_cnt;
    logic [31:0]   to_cnt;
    logic [DW-1:0] resp_buf;
    logic [2:0]    resp_left;
    logic          acc, tx_acc, in_frame, timeout;
`ifdef UART2AHB_CKSUM_EN
    logic [7:0]    cks;
`endif

    assign acc     = rx_valid & rx_ready;
    assign tx_acc  = tx_valid & tx_ready;
    assign tx_data = resp_buf[7:0];
    assign busy    = (state != ST_CMD);

`ifdef UART2AHB_CKSUM_EN
    assign in_frame = (state == ST_ADDR) || (state == ST_WDATA) || (state == ST_CKSUM);
`else
    assign in_frame = (state == ST_ADDR) || (state == ST_WDATA);
`endif

    // Fires on the edge where the idle count would reach the limit; an accepted byte wins.
    assign timeout = (TIMEOUT_CYCLES != 0) && in_frame && !acc &&
                     (to_cnt == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        nxt = state;
        case (state)
            ST_CMD:
                if (acc) nxt = (rx_data == CMD_W || rx_data == CMD_R) ? ST_ADDR : ST_RESP;
            ST_ADDR:
                if (acc && byte_cnt == 2'd3) begin
`ifdef UART2AHB_CKSUM_EN
                    nxt = dir ? ST_WDATA : ST_CKSUM;
`else
                    nxt = dir ? ST_WDATA : ST_BUS;
`endif
                end else if (timeout) nxt = ST_CMD;
            ST_WDATA:
                if (acc && byte_cnt == 2'd3) begin
`ifdef UART2AHB_CKSUM_EN
                    nxt = ST_CKSUM;
`else
                    nxt = ST_BUS;
`endif
                end else if (timeout) nxt = ST_CMD;
`ifdef UART2AHB_CKSUM_EN
            ST_CKSUM:
                if (acc) nxt = (rx_data == cks) ? ST_BUS : ST_RESP;
                else if (timeout) nxt = ST_CMD;
`endif
            ST_BUS:
                if (hready) nxt = ST_RESP;
            ST_RESP:
                if (tx_acc && resp_left == 3'd1) nxt = ST_CMD;
            default: nxt = ST_CMD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CMD;
            rx_ready  <= 1'b0;
            tx_valid  <= 1'b0;
            hsel      <= 1'b0;
            hwrite    <= 1'b0;
            haddr     <= '0;
            hwdata    <= '0;
            dir       <= 1'b0;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            resp_buf  <= '0;
            resp_left <= '0;
`ifdef UART2AHB_CKSUM_EN
            cks       <= '0;
`endif
        end else begin
            state    <= nxt;
            rx_ready <= (nxt != ST_BUS) && (nxt != ST_RESP);
            tx_valid <= (nxt == ST_RESP);
            hsel     <= (nxt == ST_BUS);
            hwrite   <= (nxt == ST_BUS) && dir;
            to_cnt   <= (acc || !in_frame) ? '0 : to_cnt + 32'd1;
            if (acc) begin
                byte_cnt <= (state == ST_CMD) ? 2'd0 : byte_cnt + 2'd1;
`ifdef UART2AHB_CKSUM_EN
                cks      <= (state == ST_CMD) ? rx_data : (cks ^ rx_data);
`endif
            end
            case (state)
                ST_CMD:
                    if (acc) begin
                        dir <= (rx_data == CMD_W);
                        if (rx_data != CMD_W && rx_data != CMD_R) begin
                            resp_buf  <= DW'(ERR_BYTE);
                            resp_left <= 3'd1;
                        end
                    end
                ST_ADDR:
                    if (acc) haddr <= {rx_data, haddr[AW-1:8]};
                ST_WDATA:
                    if (acc) hwdata <= {rx_data, hwdata[DW-1:8]};
`ifdef UART2AHB_CKSUM_EN
                ST_CKSUM:
                    if (acc && rx_data != cks) begin
                        resp_buf  <= DW'(CKSUM_ERR);
                        resp_left <= 3'd1;
                    end
`endif
                ST_BUS:
                    if (hready) begin
                        if (hresp) begin
                            resp_buf  <= DW'(ERR_BYTE);
                            resp_left <= 3'd1;
                        end else if (dir) begin
                            resp_buf  <= DW'(ACK_BYTE);
                            resp_left <= 3'd1;
                        end else begin
                            resp_buf  <= hrdata;
                            resp_left <= 3'd4;
                        end
                    end
                ST_RESP:
                    if (tx_acc) begin
                        resp_buf  <= resp_buf >> 8;
                        resp_left <= resp_left - 3'd1;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart2ahb_master.sv
// Randomized bench for uart2ahb_master against a transaction-level model of
// command bytes, expected bus transfer and expected response bytes.
module tb_uart2ahb_master;

    localparam logic [7:0] CW = 8'h57;
    localparam logic [7:0] CR = 8'h52;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hsel, hready, hresp, busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          len;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } pulse_t;

    logic [7:0]  txq[$];
    pulse_t      pulses[$];
    int          bus_wait = 0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;
    int          bus_cyc = 0;
    pulse_t      cur;
    int          hold_at = -1;
    int          hold_len = 0;
    logic        tx_pend;
    logic [7:0]  tx_held;

    uart2ahb_master #(
        .TIMEOUT_CYCLES(50),
        .ERR_BYTE(8'hEE),
        .ACK_BYTE(8'h4B)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hsel(hsel),
        .hready(hready), .hresp(hresp), .hrdata(hrdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // AHB slave: hready after bus_wait wait states, records each hsel pulse.
    initial begin
        hready = 1'b0; hresp = 1'b0; hrdata = '0;
        forever begin
            @(negedge clk);
            if (hsel) begin
                if (bus_cyc == 0) begin
                    cur.addr = haddr; cur.data = hwdata; cur.wr = hwrite;
                end else begin
                    check("haddr_stable", haddr, cur.addr);
                    check("hwdata_stable", hwdata, cur.data);
                    check("hwrite_stable", {31'd0, hwrite}, {31'd0, cur.wr});
                end
                bus_cyc++;
                hready = (bus_cyc > bus_wait);
                hresp  = hready ? bus_err : 1'($urandom);
                hrdata = hready ? bus_rdata : $urandom;
            end else begin
                if (bus_cyc != 0) begin
                    cur.len = bus_cyc;
                    pulses.push_back(cur);
                    bus_cyc = 0;
                end
                hready = 1'($urandom); hresp = 1'($urandom); hrdata = $urandom;
            end
        end
    end

    // UART transmitter side: random tx_ready with an optional forced stall.
    initial begin
        tx_ready = 1'b0; tx_pend = 1'b0; tx_held = '0;
        forever begin
            @(negedge clk);
            if (tx_valid && hold_at == txq.size() && hold_len > 0) begin
                tx_ready = 1'b0;
                hold_len--;
            end else begin
                tx_ready = ($urandom % 4) != 0;
            end
            if (tx_pend) begin
                check("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
                check("tx_data_hold", {24'd0, tx_data}, {24'd0, tx_held});
            end
            if (tx_valid && tx_ready) txq.push_back(tx_data);
            tx_pend = tx_valid && !tx_ready;
            tx_held = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", {31'd0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                           input int bwait, input logic berr, input logic [31:0] rdata,
                           input logic bad_ck, input int stall_pos, input int stall_len);
        logic [7:0] bytes[$];
        logic [7:0] exp[$];
        logic       known, ck_ok;
        int         n;
`ifdef UART2AHB_CKSUM_EN
        logic [7:0] ck;
`endif
        bus_wait = bwait; bus_err = berr; bus_rdata = rdata;
        txq.delete(); pulses.delete();
        known = (cmd == CW) || (cmd == CR);
        ck_ok = 1'b1;
        bytes.push_back(cmd);
        if (known) begin
            for (int i = 0; i < 4; i++) bytes.push_back(addr[8*i +: 8]);
            if (cmd == CW) for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
        end
`ifdef UART2AHB_CKSUM_EN
        if (known) begin
            ck = '0;
            foreach (bytes[i]) ck ^= bytes[i];
            bytes.push_back(bad_ck ? ~ck : ck);
            ck_ok = !bad_ck;
        end
`endif
        if (!known)      exp.push_back(8'hEE);
        else if (!ck_ok) exp.push_back(8'hCE);
        else if (berr)   exp.push_back(8'hEE);
        else if (cmd == CW) exp.push_back(8'h4B);
        else for (int i = 0; i < 4; i++) exp.push_back(rdata[8*i +: 8]);

        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i == stall_pos) repeat (stall_len) @(negedge clk);
            else repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n = 0;
        while (txq.size() < exp.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);

        check("tx_count", txq.size(), exp.size());
        foreach (exp[i]) if (i < txq.size()) check("tx_byte", {24'd0, txq[i]}, {24'd0, exp[i]});
        check("hsel_pulses", pulses.size(), (known && ck_ok) ? 1 : 0);
        if (known && ck_ok && pulses.size() > 0) begin
            check("hsel_len", pulses[0].len, bwait + 1);
            check("haddr", pulses[0].addr, addr);
            check("hwrite", {31'd0, pulses[0].wr}, (cmd == CW) ? 32'd1 : 32'd0);
            if (cmd == CW) check("hwdata", pulses[0].data, data);
        end
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] c;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_hsel", {31'd0, hsel}, 32'd0);
        check("rst_hwrite", {31'd0, hwrite}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);

        run_txn(CW, 32'h80000010, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1'b0, -1, 0);
        hold_at = 1; hold_len = 5;
        run_txn(CR, 32'h80000004, 32'h0, 0, 1'b0, 32'h12345678, 1'b0, -1, 0);
        hold_at = -1; hold_len = 0;
        run_txn(CR, 32'h00000100, 32'h0, 1, 1'b1, 32'hCAFEF00D, 1'b0, -1, 0);
        run_txn(8'h41, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0, -1, 0);
        run_txn(CR, 32'h00000203, 32'h0, 0, 1'b0, 32'hA5A55A5A, 1'b0, -1, 0);

        // Partial command abandoned after 50 idle cycles, silently.
        txq.delete(); pulses.delete();
        send_byte(CW);
        send_byte(8'h10);
        repeat (49) @(negedge clk);
        check("timeout_not_yet", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        check("timeout_no_tx", txq.size(), 0);
        check("timeout_no_hsel", pulses.size(), 0);
        run_txn(CR, 32'h80000008, 32'h0, 0, 1'b0, 32'h0BADBEEF, 1'b0, -1, 0);
        run_txn(CW, 32'h90000010, 32'h01020304, 1, 1'b0, 32'h0, 1'b0, 1, 49);

`ifdef UART2AHB_CKSUM_EN
        run_txn(CR, 32'h80000004, 32'h0, 0, 1'b0, 32'h12345678, 1'b0, -1, 0);
        run_txn(CR, 32'h80000004, 32'h0, 0, 1'b0, 32'h12345678, 1'b1, -1, 0);
        run_txn(CW, 32'h80000020, 32'h55AA55AA, 0, 1'b0, 32'h0, 1'b1, -1, 0);
`endif

        // Reset asserted while the bus transfer is stalled.
        bus_wait = 40; bus_err = 1'b0;
        send_byte(CR);
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); send_byte(8'h80);
`ifdef UART2AHB_CKSUM_EN
        send_byte(8'hD6);
`endif
        n = 0;
        while (!hsel && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hsel_before_rst", {31'd0, hsel}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hsel", {31'd0, hsel}, 32'd0);
        check("async_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rel", {31'd0, rx_ready}, 32'd1);
        run_txn(CR, 32'h80000004, 32'h0, 0, 1'b0, 32'h87654321, 1'b0, -1, 0);

        for (int k = 0; k < 25; k++) begin
            r = $urandom % 8;
            if (r == 0) begin
                c = 8'($urandom);
                if (c == CW || c == CR) c = c ^ 8'h01;
            end else if (r < 4) c = CW;
            else c = CR;
            run_txn(c, $urandom, $urandom, $urandom_range(0, 3), ($urandom % 8) == 0,
                    $urandom, ($urandom % 6) == 0, -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
